// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: the 3-bit mode
// encoding and its type.
package usr_pkg;

    typedef logic [2:0] mode_t;

    localparam mode_t MODE_HOLD = 3'b000;
    localparam mode_t MODE_LOAD = 3'b001;
    localparam mode_t MODE_SHL  = 3'b010;
    localparam mode_t MODE_SHR  = 3'b011;
    localparam mode_t MODE_ROTL = 3'b100;
    localparam mode_t MODE_ROTR = 3'b101;
    localparam mode_t MODE_ASHR = 3'b110;
    localparam mode_t MODE_CLR  = 3'b111;

endpackage

// File: rtl/usr_next_mux.sv
// Next-state selector for univ_shift_reg. Purely combinational, so the
// register process in the top stays a plain enable-gated flop.
module usr_next_mux
    import usr_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic [WIDTH-1:0] Q,
    input  logic [WIDTH-1:0] D,
    input  logic             Sin_l,
    input  logic             Sin_r,
    input  mode_t            Mode,
    output logic [WIDTH-1:0] Qnext
);

    // Select the next register contents from the current mode.
    always_comb begin
        Qnext = Q;
        case (Mode)
            MODE_HOLD: Qnext = Q;
            MODE_LOAD: Qnext = D;
            MODE_SHL:  Qnext = {Q[WIDTH-2:0], Sin_l};
            MODE_SHR:  Qnext = {Sin_r, Q[WIDTH-1:1]};
            MODE_ROTL: Qnext = {Q[WIDTH-2:0], Q[WIDTH-1]};
            MODE_ROTR: Qnext = {Q[0], Q[WIDTH-1:1]};
            MODE_ASHR: Qnext = {Q[WIDTH-1], Q[WIDTH-1:1]};
            MODE_CLR:  Qnext = RST_VAL;
            default:   Qnext = Q;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register: hold/load/shift/rotate/arith-shift/
// clear, serial in/out, clock enable and true/complement outputs.
// Define USR_PARITY_EN to add a registered parity output Par that tracks
// the XOR-reduction of Q.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             En,
    input  mode_t            Mode,
    input  logic [WIDTH-1:0] D,
    input  logic             Sin_l,
    input  logic             Sin_r,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic             Sout_l,
    output logic             Sout_r
`ifdef USR_PARITY_EN
   ,output logic             Par
`endif
);

    logic [WIDTH-1:0] qnext;

    usr_next_mux #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
    ) u_next (
        .Q     (Q),
        .D     (D),
        .Sin_l (Sin_l),
        .Sin_r (Sin_r),
        .Mode  (Mode),
        .Qnext (qnext)
    );

    // Main register; reset release is assumed to meet recovery timing.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)  Q <= RST_VAL;
        else if (En)   Q <= qnext;
    end

`ifdef USR_PARITY_EN
    // Parity of the value Q takes on this edge, so Par and Q move together.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)  Par <= ^RST_VAL;
        else if (En)   Par <= ^qnext;
    end
`endif

    assign Qbar   = ~Q;
    assign Sout_l = Q[WIDTH-1];
    assign Sout_r = Q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8, RST_VAL=A5): directed
// vectors with literal expectations plus an every-cycle arithmetic model.
module tb_univ_shift_reg;
    import usr_pkg::*;

    localparam int         W  = 8;
    localparam logic [7:0] RV = 8'hA5;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       En;
    mode_t      Mode;
    logic [7:0] D;
    logic       Sin_l, Sin_r;
    logic [7:0] Q, Qbar;
    logic       Sout_l, Sout_r;
`ifdef USR_PARITY_EN
    logic       Par;
`endif

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;
    logic [7:0] model;

    univ_shift_reg #(.WIDTH(W), .RST_VAL(RV)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .En      (En),
        .Mode    (Mode),
        .D       (D),
        .Sin_l   (Sin_l),
        .Sin_r   (Sin_r),
        .Q       (Q),
        .Qbar    (Qbar),
        .Sout_l  (Sout_l),
        .Sout_r  (Sout_r)
`ifdef USR_PARITY_EN
       ,.Par     (Par)
`endif
    );

    always #5 Clk = ~Clk;

    // Mode must be known whenever the register is enabled.
    always @(posedge Clk)
        if (Reset_n === 1'b1 && En === 1'b1)
            assert (!$isunknown(Mode)) else $error("Mode is X/Z while enabled");

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Next value from the operation's arithmetic meaning.
    function automatic logic [7:0] ref_next(input logic [7:0] m, input logic [2:0] md,
                                            input logic [7:0] d, input logic sl, input logic sr);
        int v;
        v = int'(m);
        case (md)
            3'd1: v = int'(d);
            3'd2: v = (v * 2 + int'(sl)) % 256;
            3'd3: v = v / 2 + (sr ? 128 : 0);
            3'd4: v = (v * 2) % 256 + v / 128;
            3'd5: v = v / 2 + (v % 2) * 128;
            3'd6: v = v / 2 + (v >= 128 ? 128 : 0);
            3'd7: v = int'(RV);
            default: v = int'(m);
        endcase
        return v[7:0];
    endfunction

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)  model <= RV;
        else if (En)   model <= ref_next(model, Mode, D, Sin_l, Sin_r);
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge Clk) begin
        if (chk_on) begin
            chk("model_Q",      {56'd0, Q},      {56'd0, model});
            chk("model_Qbar",   {56'd0, Qbar},   {56'd0, ~model});
            chk("model_Sout_l", {63'd0, Sout_l}, {63'd0, model[7]});
            chk("model_Sout_r", {63'd0, Sout_r}, {63'd0, model[0]});
`ifdef USR_PARITY_EN
            chk("model_Par",    {63'd0, Par},    {63'd0, ^model});
`endif
        end
    end

    // Apply one operation across one rising edge; returns at edge + 1.
    task automatic step(input logic [2:0] md, input logic [7:0] d = 8'h00,
                        input logic sl = 1'b0, input logic sr = 1'b0, input logic en = 1'b1);
        Mode = md; D = d; Sin_l = sl; Sin_r = sr; En = en;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset_n = 1'b1; En = 1'b0; Mode = MODE_HOLD; D = '0; Sin_l = 0; Sin_r = 0;
        // Reset asserted mid-cycle, takes effect without a clock edge.
        #2 Reset_n = 1'b0;
        #1;
        chk("rst_Q",    {56'd0, Q},    64'hA5);
        chk("rst_Qbar", {56'd0, Qbar}, 64'h5A);
        chk_on = 1'b1;
        @(posedge Clk); #1 Reset_n = 1'b1;

        step(MODE_LOAD, 8'h3C);
        chk("load_3C", {56'd0, Q}, 64'h3C);

        step(MODE_LOAD, 8'h81);
        chk("sout_l_pre", {63'd0, Sout_l}, 64'd1);
        step(MODE_SHL, 8'h00, 1'b1);
        chk("shl_03", {56'd0, Q}, 64'h03);
        for (int i = 0; i < 8; i++) step(MODE_SHL, 8'h00, 1'b0);
        chk("shl8_00", {56'd0, Q}, 64'h00);

        step(MODE_LOAD, 8'h81);
        step(MODE_ROTR);
        chk("rotr_C0", {56'd0, Q}, 64'hC0);
        step(MODE_ROTL);
        chk("rotl_81", {56'd0, Q}, 64'h81);
        for (int i = 0; i < 8; i++) step(MODE_ROTL);
        chk("rotl8_81", {56'd0, Q}, 64'h81);

        step(MODE_LOAD, 8'h80);
        for (int i = 0; i < 3; i++) step(MODE_ASHR);
        chk("ashr3_F0", {56'd0, Q}, 64'hF0);
        step(MODE_LOAD, 8'h40);
        step(MODE_ASHR, 8'h00, 1'b1, 1'b1);
        chk("ashr_20", {56'd0, Q}, 64'h20);
        step(MODE_LOAD, 8'hFF);
        step(MODE_ASHR);
        chk("ashr_FF", {56'd0, Q}, 64'hFF);
        step(MODE_LOAD, 8'h80);
        for (int i = 0; i < 7; i++) step(MODE_ASHR);
        chk("ashr7_FF", {56'd0, Q}, 64'hFF);

        step(MODE_LOAD, 8'h20);
        step(MODE_LOAD, 8'hFF, 1'b0, 1'b0, 1'b0);
        chk("en0_hold", {56'd0, Q}, 64'h20);
        step(MODE_CLR);
        chk("clr_A5", {56'd0, Q}, 64'hA5);

        step(MODE_LOAD, 8'h3C);
        step(MODE_SHR, 8'h00, 1'b0, 1'b1);
        chk("shr_9E", {56'd0, Q}, 64'h9E);
        #1 Reset_n = 1'b0;
        #1 chk("midrst_A5", {56'd0, Q}, 64'hA5);
        #1 Reset_n = 1'b1;
        step(MODE_SHR, 8'h00, 1'b1, 1'b0);
        chk("shr_resume_52", {56'd0, Q}, 64'h52);
        for (int i = 0; i < 8; i++) step(MODE_SHR, 8'h00, 1'b0, 1'b1);
        chk("shr8_FF", {56'd0, Q}, 64'hFF);
        step(MODE_HOLD, 8'h12, 1'b0, 1'b0);
        chk("hold_FF", {56'd0, Q}, 64'hFF);
        step(MODE_SHL, 8'h00, 1'b1, 1'b0);
        chk("shl_sinl_only", {56'd0, Q}, 64'hFF);

`ifdef USR_PARITY_EN
        step(MODE_LOAD, 8'h07);
        chk("par_07", {63'd0, Par}, 64'd1);
        step(MODE_SHL, 8'h00, 1'b0);
        chk("shl_0E", {56'd0, Q}, 64'h0E);
        chk("par_0E", {63'd0, Par}, 64'd1);
        step(MODE_LOAD, 8'h03);
        chk("par_03", {63'd0, Par}, 64'd0);
`endif

        step(MODE_HOLD);
        @(negedge Clk); #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised successor to the team's single-bit D flip-flop: a WIDTH-bit register with selectable load/shift/rotate modes, serial in/out, clock enable and true/complement outputs.
- Used as the generic storage and serialisation element in datapaths: serial-to-parallel and parallel-to-serial converters, LFSR/rotator front-ends, and pipeline holding registers.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..64.
- RST_VAL, 0, WIDTH-bit value loaded on asynchronous reset and on the CLR mode.

Ports:
- Clk  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous active-low reset.
- En  input  1  clock enable; when 0 the register holds regardless of Mode.
- Mode  input  3  operation select, see Behaviour.
- D  input  WIDTH  parallel load data.
- Sin_l  input  1  serial input entering at bit 0 on shift-left.
- Sin_r  input  1  serial input entering at bit WIDTH-1 on shift-right.
- Q  output  WIDTH  register contents.
- Qbar  output  WIDTH  bitwise complement of Q, combinational.
- Sout_l  output  1  Q[WIDTH-1], the bit that leaves on shift-left.
- Sout_r  output  1  Q[0], the bit that leaves on shift-right.

Behaviour:
- Reset_n low, asynchronous: Q = RST_VAL immediately, independent of Clk; Qbar = ~RST_VAL; Sout_l and Sout_r follow Q.
- Release of Reset_n is not re-synchronised here; the caller guarantees deassertion meets recovery timing.
- All updates occur on the rising Clk edge only when Reset_n = 1 and En = 1. With En = 0, Q holds.
- Latency: one cycle from inputs to Q. Qbar, Sout_l and Sout_r are combinational from Q with no added latency.
- Mode encoding:
  - 000 HOLD: Q unchanged.
  - 001 LOAD: Q = D.
  - 010 SHL: Q = {Q[WIDTH-2:0], Sin_l}.
  - 011 SHR: Q = {Sin_r, Q[WIDTH-1:1]}.
  - 100 ROTL: Q = {Q[WIDTH-2:0], Q[WIDTH-1]}.
  - 101 ROTR: Q = {Q[0], Q[WIDTH-1:1]}.
  - 110 ASHR: Q = {Q[WIDTH-1], Q[WIDTH-1:1]} (sign-preserving).
  - 111 CLR: Q = RST_VAL, synchronous.
- Rotates and ASHR ignore Sin_l and Sin_r. Only SHL samples Sin_l; only SHR samples Sin_r.
- Boundaries:
  - WIDTH rotations return the original value.
  - WIDTH shifts fully replace the contents with serial data.
  - ASHR on all-ones stays all-ones; ASHR on the MSB-only value converges to all-ones after WIDTH-1 cycles.
- Reset asserted mid-shift aborts the operation; the first post-reset edge with En = 1 operates on RST_VAL.
- Unknown or X on Mode while En = 1 is not recoverable; the bench flags it via assertion.
- The register has no internal state machine beyond Q. All state is visible on Q.

Optional Feature:
- Macro USR_PARITY_EN.
- Defined:
  - Adds output port Par (1 bit), registered, equal to XOR-reduction of the next Q value.
  - Par updates on the same edge as Q and resets to ^RST_VAL.
  - Par holds when En = 0.
- Undefined: Par port and its flop are absent; behaviour is otherwise identical.

Decomposition:
- Package usr_pkg:
  - 3-bit mode localparams MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROTL, MODE_ROTR, MODE_ASHR, MODE_CLR.
  - A mode_t typedef.
- Sub-module usr_next_mux: purely combinational. Computes the next Q from Q, D, Sin_l, Sin_r and Mode, keeping the flop process in the top trivial.
- Top instantiates usr_next_mux plus the WIDTH-bit register (and the Par flop when enabled).

Test Plan:
- Reset and load: Reset_n = 0 mid-cycle with WIDTH = 8, RST_VAL = 8'hA5 -> Q = A5 immediately, Qbar = 5A. Release, then LOAD D = 3C -> Q = 3C next edge.
- Shift-left: Q = 81, SHL with Sin_l = 1 -> Q = 03, Sout_l was 1 before the edge. Eight SHL with Sin_l = 0 -> Q = 00.
- Rotate: Q = 81, ROTR once -> C0; ROTL once -> 81; eight ROTL -> 81.
- ASHR: Q = 80, ASHR ×3 -> F0. Q = 40, ASHR -> 20.
- Enable and clear: En = 0 with Mode = LOAD, D = FF -> Q unchanged. En = 1, CLR -> Q = A5. Reset_n pulsed low between edges during an SHR stream -> Q = A5 and the shift resumes from A5.
- USR_PARITY_EN: LOAD 07 -> Par = 1 on the same edge. SHL with Sin_l = 0 -> Q = 0E, Par = 1. LOAD 03 -> Par = 0.
